univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: W-bit register with hold, logical/arithmetic shift, rotate and parallel-load modes, selected per cycle. Adds a burst engine that performs a programmed number of single-bit steps autonomously with Busy/Done handshake. It is the general-purpose successor to the fixed 4-bit right-shift/load register and serves as the serial/parallel conversion and bit-alignment element in the Ch08-family datapaths.

## Interface
- W, 8, register width; legal range W ≥ 2.
- AW, 4, width of Amt; must satisfy 2^AW > W.

- Clk  input  1  clock; all state updates on the falling edge.
- Rst  input  1  synchronous, active-high reset, sampled on the falling edge of Clk.
- En  input  1  single-step enable, used when idle.
- Mode  input  3  operation select (encoding below).
- SerR  input  1  serial bit entering at MSB on right shift.
- SerL  input  1  serial bit entering at LSB on left shift.
- D  input  W  parallel load data.
- Start  input  1  begin burst of Amt steps of Mode.
- Amt  input  AW  burst step count.
- Q  output  W  register contents.
- SoR  output  1  Q[0], the bit leaving on right shift (combinational from Q).
- SoL  output  1  Q[W-1], the bit leaving on left shift (combinational from Q).
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle burst-complete pulse.

## Operation
- Mode encoding, one step: 0 hold; 1 SRL Q←{SerR,Q[W-1:1]}; 2 SLL Q←{Q[W-2:0],SerL}; 3 ROR Q←{Q[0],Q[W-1:1]}; 4 ROL Q←{Q[W-2:0],Q[W-1]}; 5 SRA Q←{Q[W-1],Q[W-1:1]}; 6 load Q←D; 7 hold (reserved).
- States: IDLE, RUN.
- IDLE priority per edge: Rst > Start with Mode in 1..5 > En.
- En=1 in IDLE with no valid Start: execute one step of Mode.
- Start=1 with Mode 0, 6 or 7 is ignored; En/Mode then act normally.
- Valid Start in IDLE:
  - latch Mode into an internal register.
  - latch count = min(Amt, W).
  - no shift on the Start edge.
  - count ≥ 1: go to RUN.
  - count = 0: stay IDLE, pulse Done, Busy stays 0.
- RUN: each edge executes one step of the latched mode and decrements count.
  - When count reaches 0 after a step: go to IDLE and pulse Done.
  - En, Mode, Start, D are ignored in RUN.
  - SerR/SerL are sampled live at each step edge.
- Rst at any time: Q=0, Busy=0, Done=0, count=0, state IDLE. This includes mid-burst; the remaining steps are discarded.
- Reset values: Q=0, SoR=0, SoL=0, Busy=0, Done=0.

## Timing
- Single step: result visible on Q after the edge on which En is sampled (1-edge latency).
- Burst of k (1..W) steps, Start sampled at edge 0:
  - shifts occur on edges 1..k.
  - Busy=1 from after edge 0 until after edge k.
  - Done=1 for exactly the cycle after edge k, coincident with Busy falling.
- Burst with Amt=0: Done=1 for the cycle after edge 0; Q unchanged.
- Amt > W: clamped to W. A ROR/ROL burst with Amt ≥ W returns the original Q.
- Start held high after a burst: a new burst begins on the first IDLE edge, which is the edge after Busy falls (back-to-back, one idle edge between bursts).
- Done never asserts together with Busy=1 in the same cycle.

## Test plan
- Reset then load, W=8:
  - Rst → Q=00, Busy=0, Done=0.
  - En=1, Mode=6, D=A5 → Q=A5, SoR=1, SoL=1.
- Single steps:
  - From A5: Mode1 with SerR=1 → D2.
  - Then Mode2 with SerL=0 → A4.
  - Load 90, Mode5 → C8.
  - Load 81: Mode4 → 03; reload 81, Mode3 → C0.
- Burst:
  - Q=A5, Start, Mode4, Amt=3 → Busy high 3 cycles, Q=2D after third step edge, Done single pulse.
  - En=1 with Mode=6, D=FF during Busy → no effect.
- Edge counts:
  - Amt=0 → Done pulse next cycle, Busy=0, Q unchanged.
  - Q=A5, Mode3, Amt=12 → clamped to 8 steps, Busy 8 cycles, Q=A5 at end.
- Reset mid-burst:
  - Q=FF, Mode1, SerR=0, Amt=6, Rst after 2 steps → Q=00, Busy=0, no Done pulse.
  - Next single step operates normally.
- Invalid Start: Start=1, Mode=6, En=1, D=3C → treated as load, Q=3C, Busy and Done stay 0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal W-bit shift register: hold, logical/arithmetic shift, rotate and load,
// plus a burst engine that runs a programmed number of single-bit steps on its own.
module univ_shift_reg #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          En,
   input  logic [2:0]    Mode,
   input  logic          SerR,
   input  logic          SerL,
   input  logic [W-1:0]  D,
   input  logic          Start,
   input  logic [AW-1:0] Amt,
   output logic [W-1:0]  Q,
   output logic          SoR,
   output logic          SoL,
   output logic          Busy,
   output logic          Done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [AW-1:0] FullCount = AW'(W);

   state_t        state;
   logic [2:0]    burstMode;
   logic [AW-1:0] count;
   logic [AW-1:0] clampedAmt;
   logic          startValid;

   // One step of the selected operation; modes 0 and 7 leave the register alone.
   function automatic logic [W-1:0] stepOnce(
      input logic [2:0]   op,
      input logic [W-1:0] cur,
      input logic         sr,
      input logic         sl,
      input logic [W-1:0] ld
   );
      logic [W-1:0] nxt;
      nxt = cur;
      case (op)
         3'd1:    nxt = {sr, cur[W-1:1]};
         3'd2:    nxt = {cur[W-2:0], sl};
         3'd3:    nxt = {cur[0], cur[W-1:1]};
         3'd4:    nxt = {cur[W-2:0], cur[W-1]};
         3'd5:    nxt = {cur[W-1], cur[W-1:1]};
         3'd6:    nxt = ld;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   // Only shift/rotate modes can be bursted; a Start with hold/load falls through to En.
   assign startValid = Start && (Mode >= 3'd1) && (Mode <= 3'd5);
   assign clampedAmt = (Amt > FullCount) ? FullCount : Amt;

   assign SoR = Q[0];
   assign SoL = Q[W-1];

   // All state advances on the falling clock edge, reset included.
   always_ff @(negedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         Q         <= '0;
         count     <= '0;
         burstMode <= 3'd0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (startValid) begin
                  burstMode <= Mode;
                  count     <= clampedAmt;
                  if (clampedAmt != '0) begin
                     state <= RUN;
                     Busy  <= 1'b1;
                  end else begin
                     Done <= 1'b1;
                  end
               end else if (En) begin
                  Q <= stepOnce(Mode, Q, SerR, SerL, D);
               end
            end
            RUN: begin
               Q     <= stepOnce(burstMode, Q, SerR, SerL, D);
               count <= count - 1'b1;
               if (count == {{(AW-1){1'b0}}, 1'b1}) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (W=8): directed scenarios plus randomized
// single steps and bursts compared against an arithmetic reference model.
module tb_univ_shift_reg;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       En = 1'b0;
   logic [2:0] Mode = 3'd0;
   logic       SerR = 1'b0;
   logic       SerL = 1'b0;
   logic [7:0] D = 8'h00;
   logic       Start = 1'b0;
   logic [3:0] Amt = 4'd0;
   logic [7:0] Q;
   logic       SoR;
   logic       SoL;
   logic       Busy;
   logic       Done;

   int nChecks = 0;
   int nFails  = 0;

   univ_shift_reg #(.W(8), .AW(4)) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .SerR(SerR), .SerL(SerL),
      .D(D), .Start(Start), .Amt(Amt), .Q(Q), .SoR(SoR), .SoL(SoL),
      .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   // Reference step written with plain integer arithmetic on an 8-bit value.
   function automatic logic [7:0] modelStep(input int op, input int q, input int sr, input int sl, input int ld);
      int r;
      case (op)
         1: r = (q >> 1) + sr * 128;
         2: r = ((q * 2) % 256) + sl;
         3: r = (q >> 1) + (q % 2) * 128;
         4: r = ((q * 2) % 256) + (q / 128);
         5: r = (q >> 1) + (q / 128) * 128;
         6: r = ld;
         default: r = q;
      endcase
      return 8'(r);
   endfunction

   // Active edge is the falling edge; drive and sample 1 time unit after it.
   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic idleInputs();
      En = 0; Start = 0; Mode = 3'd0; Amt = 4'd0; SerR = 0; SerL = 0; D = 8'h00;
   endtask

   task automatic loadValue(input logic [7:0] v);
      En = 1; Mode = 3'd6; D = v; Start = 0;
      tick();
      idleInputs();
   endtask

   task automatic test_reset();
      idleInputs();
      Rst = 1;
      tick();
      tick();
      Rst = 0;
      nChecks++; if (Q !== 8'h00) begin nFails++; $display("[TB] FAIL reset_q: got %h want 00", Q); end
      nChecks++; if (Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: got busy=%b done=%b want 0/0", Busy, Done); end
      nChecks++; if (SoR !== 1'b0 || SoL !== 1'b0) begin nFails++; $display("[TB] FAIL reset_serial_out: got sor=%b sol=%b want 0/0", SoR, SoL); end
   endtask

   task automatic test_single_steps();
      loadValue(8'hA5);
      nChecks++; if (Q !== 8'hA5) begin nFails++; $display("[TB] FAIL load_a5: got %h want a5", Q); end
      nChecks++; if (SoR !== 1'b1 || SoL !== 1'b1) begin nFails++; $display("[TB] FAIL load_a5_so: got sor=%b sol=%b want 1/1", SoR, SoL); end
      En = 1; Mode = 3'd1; SerR = 1; tick();
      nChecks++; if (Q !== 8'hD2) begin nFails++; $display("[TB] FAIL srl_step: got %h want d2", Q); end
      Mode = 3'd2; SerL = 0; tick();
      nChecks++; if (Q !== 8'hA4) begin nFails++; $display("[TB] FAIL sll_step: got %h want a4", Q); end
      idleInputs();
      loadValue(8'h90);
      En = 1; Mode = 3'd5; tick();
      nChecks++; if (Q !== 8'hC8) begin nFails++; $display("[TB] FAIL sra_step: got %h want c8", Q); end
      idleInputs();
      loadValue(8'h81);
      En = 1; Mode = 3'd4; tick();
      nChecks++; if (Q !== 8'h03) begin nFails++; $display("[TB] FAIL rol_step: got %h want 03", Q); end
      idleInputs();
      loadValue(8'h81);
      En = 1; Mode = 3'd3; tick();
      nChecks++; if (Q !== 8'hC0) begin nFails++; $display("[TB] FAIL ror_step: got %h want c0", Q); end
      Mode = 3'd7; tick();
      nChecks++; if (Q !== 8'hC0) begin nFails++; $display("[TB] FAIL mode7_hold: got %h want c0", Q); end
      idleInputs();
   endtask

   task automatic test_burst();
      loadValue(8'hA5);
      Start = 1; Mode = 3'd4; Amt = 4'd3;
      tick();
      // Try to disturb the burst with a load request while busy.
      Start = 0; En = 1; Mode = 3'd6; D = 8'hFF;
      nChecks++; if (Busy !== 1'b1 || Done !== 1'b0 || Q !== 8'hA5) begin nFails++; $display("[TB] FAIL burst_start_edge: got busy=%b done=%b q=%h want 1/0/a5", Busy, Done, Q); end
      tick();
      nChecks++; if (Busy !== 1'b1 || Done !== 1'b0 || Q !== 8'h4B) begin nFails++; $display("[TB] FAIL burst_step1: got busy=%b done=%b q=%h want 1/0/4b", Busy, Done, Q); end
      tick();
      nChecks++; if (Busy !== 1'b1 || Done !== 1'b0 || Q !== 8'h96) begin nFails++; $display("[TB] FAIL burst_step2: got busy=%b done=%b q=%h want 1/0/96", Busy, Done, Q); end
      En = 0;
      tick();
      nChecks++; if (Busy !== 1'b0 || Done !== 1'b1 || Q !== 8'h2D) begin nFails++; $display("[TB] FAIL burst_end: got busy=%b done=%b q=%h want 0/1/2d", Busy, Done, Q); end
      idleInputs();
      tick();
      nChecks++; if (Done !== 1'b0 || Q !== 8'h2D) begin nFails++; $display("[TB] FAIL burst_done_pulse: got done=%b q=%h want 0/2d", Done, Q); end
   endtask

   task automatic test_amt_zero();
      loadValue(8'h5C);
      Start = 1; Mode = 3'd1; Amt = 4'd0; SerR = 1;
      tick();
      idleInputs();
      nChecks++; if (Done !== 1'b1 || Busy !== 1'b0 || Q !== 8'h5C) begin nFails++; $display("[TB] FAIL amt_zero: got done=%b busy=%b q=%h want 1/0/5c", Done, Busy, Q); end
      tick();
      nChecks++; if (Done !== 1'b0 || Q !== 8'h5C) begin nFails++; $display("[TB] FAIL amt_zero_after: got done=%b q=%h want 0/5c", Done, Q); end
   endtask

   task automatic test_clamp();
      int busyCycles;
      loadValue(8'hA5);
      Start = 1; Mode = 3'd3; Amt = 4'd12;
      tick();
      idleInputs();
      busyCycles = 0;
      while (Busy === 1'b1 && busyCycles < 20) begin
         busyCycles++;
         tick();
      end
      nChecks++; if (busyCycles != 8) begin nFails++; $display("[TB] FAIL clamp_busy_len: got %0d want 8", busyCycles); end
      nChecks++; if (Q !== 8'hA5 || Done !== 1'b1) begin nFails++; $display("[TB] FAIL clamp_result: got q=%h done=%b want a5/1", Q, Done); end
      tick();
   endtask

   task automatic test_reset_mid_burst();
      loadValue(8'hFF);
      Start = 1; Mode = 3'd1; SerR = 0; Amt = 4'd6;
      tick();
      Start = 0;
      tick();
      tick();
      nChecks++; if (Q !== 8'h3F || Busy !== 1'b1) begin nFails++; $display("[TB] FAIL mid_burst_progress: got q=%h busy=%b want 3f/1", Q, Busy); end
      Rst = 1;
      tick();
      Rst = 0;
      nChecks++; if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL mid_burst_reset: got q=%h busy=%b done=%b want 00/0/0", Q, Busy, Done); end
      idleInputs();
      tick();
      nChecks++; if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_quiet: got q=%h busy=%b done=%b want 00/0/0", Q, Busy, Done); end
      En = 1; Mode = 3'd2; SerL = 1;
      tick();
      idleInputs();
      nChecks++; if (Q !== 8'h01) begin nFails++; $display("[TB] FAIL post_reset_step: got %h want 01", Q); end
   endtask

   task automatic test_invalid_start();
      Start = 1; Mode = 3'd6; En = 1; D = 8'h3C; Amt = 4'd4;
      tick();
      nChecks++; if (Q !== 8'h3C || Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL invalid_start: got q=%h busy=%b done=%b want 3c/0/0", Q, Busy, Done); end
      Mode = 3'd0; En = 0;
      tick();
      nChecks++; if (Q !== 8'h3C || Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL invalid_start_hold: got q=%h busy=%b done=%b want 3c/0/0", Q, Busy, Done); end
      idleInputs();
   endtask

   task automatic test_back_to_back();
      loadValue(8'h01);
      Start = 1; Mode = 3'd2; SerL = 0; Amt = 4'd2;
      tick();
      tick();
      tick();
      nChecks++; if (Busy !== 1'b0 || Done !== 1'b1 || Q !== 8'h04) begin nFails++; $display("[TB] FAIL b2b_first_end: got busy=%b done=%b q=%h want 0/1/04", Busy, Done, Q); end
      tick();
      nChecks++; if (Busy !== 1'b1 || Done !== 1'b0 || Q !== 8'h04) begin nFails++; $display("[TB] FAIL b2b_restart: got busy=%b done=%b q=%h want 1/0/04", Busy, Done, Q); end
      Start = 0;
      tick();
      tick();
      nChecks++; if (Busy !== 1'b0 || Done !== 1'b1 || Q !== 8'h10) begin nFails++; $display("[TB] FAIL b2b_second_end: got busy=%b done=%b q=%h want 0/1/10", Busy, Done, Q); end
      idleInputs();
      tick();
   endtask

   task automatic test_random_steps();
      logic [7:0] expQ;
      int op;
      expQ = Q;
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 7));
         En = 1'($urandom);
         Mode = 3'(op);
         SerR = 1'($urandom);
         SerL = 1'($urandom);
         D = 8'($urandom);
         // Start only with non-burstable modes here, which must be ignored.
         Start = (op == 0 || op >= 6) ? 1'($urandom) : 1'b0;
         Amt = 4'($urandom);
         if (En) expQ = modelStep(op, expQ, SerR, SerL, D);
         tick();
         nChecks++; if (Q !== expQ || Busy !== 1'b0 || Done !== 1'b0) begin nFails++; $display("[TB] FAIL rand_step_%0d: got q=%h busy=%b done=%b want %h/0/0", i, Q, Busy, Done, expQ); end
      end
      idleInputs();
   endtask

   task automatic test_random_bursts();
      logic [7:0] expQ;
      int op, amount, steps, busyCycles;
      for (int b = 0; b < 20; b++) begin
         loadValue(8'($urandom));
         expQ = Q;
         op = int'($urandom_range(1, 5));
         amount = int'($urandom_range(0, 15));
         steps = (amount > 8) ? 8 : amount;
         Start = 1; Mode = 3'(op); Amt = 4'(amount);
         SerR = 1'($urandom); SerL = 1'($urandom);
         tick();
         Start = 0; En = 1'($urandom); Mode = 3'd6; D = 8'($urandom);
         for (int s = 0; s < steps; s++) expQ = modelStep(op, expQ, SerR, SerL, 0);
         busyCycles = 0;
         while (Busy === 1'b1 && busyCycles < 20) begin
            nChecks++; if (Done !== 1'b0) begin nFails++; $display("[TB] FAIL rand_burst_overlap_%0d: got done=%b with busy=1 want done=0", b, Done); end
            busyCycles++;
            tick();
         end
         nChecks++; if (busyCycles != steps) begin nFails++; $display("[TB] FAIL rand_burst_len_%0d: got %0d want %0d", b, busyCycles, steps); end
         nChecks++; if (Q !== expQ || Done !== 1'b1) begin nFails++; $display("[TB] FAIL rand_burst_result_%0d: got q=%h done=%b want %h/1", b, Q, Done, expQ); end
         idleInputs();
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_steps();
      test_burst();
      test_amt_zero();
      test_clamp();
      test_reset_mid_burst();
      test_invalid_start();
      test_back_to_back();
      test_random_steps();
      test_random_bursts();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
